wb_regfile: RTL

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 41 ++++
 1 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: write-back register file (clk/reset, MEM/WB write port, rs1/rs2 bypassed reads, WB_DATA, wb_we, retired count)
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] DO_MEMo,
  input  logic [DATA_W-1:0] Y_ALUo,
  input  logic [ADDR_W-1:0] rd_o,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] WB_DATA,
  output logic              wb_we,
  output logic [31:0]       retired
);
  logic [DATA_W-1:0] regs [2**ADDR_W];
  logic we;
  always_comb begin
    WB_DATA = MemtoReg ? DO_MEMo : Y_ALUo;
    we = wb_valid & RegWrite & (rd_o != '0);
    RD1 = (rs1 == '0) ? '0 : (we && rs1 == rd_o) ? WB_DATA : regs[rs1];
    RD2 = (rs2 == '0) ? '0 : (we && rs2 == rd_o) ? WB_DATA : regs[rs2];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
      wb_we <= 1'b0;
      retired <= '0;
    end else begin
      if (we) regs[rd_o] <= WB_DATA;
      wb_we <= we;
      if (wb_valid) retired <= retired + 32'd1;
    end
  end
endmodule
